fp_decode_seq: RTL

Sequential floating-point-to-linear converter, the inverse of the FPCVT encoder. It accepts the 8-bit sign/exponent/mantissa triple (S, E, F) that FPCVT produces and expands it to a 12-bit two's-complement sample: D = (-1)^S × F × 2^E. Sits on the decode side of the sample path, with valid/ready handshakes on both ports. By default it expands with an iterative one-bit-per-cycle shifter.

---
 rtl/fp_decode_seq.sv | 101 ++++++++++
 1 files changed

// File: rtl/fp_decode_seq.sv
// Expands an FPCVT (S,E,F) triple to a 12b two's-complement sample D = +/-(F<<E). Latency E+1 cycles (iterative), or accept-edge result with FPDEC_FASTSHIFT_EN.
// Upstream is stalled (in_ready=0) from accept until the output handshake; D/out_valid hold while out_ready is low.
module fp_decode_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        S,
  input  logic [2:0]  E,
  input  logic [3:0]  F,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] D
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_accept;
  logic [11:0] r_d;

  assign w_accept = (r_state == ST_IDLE) && in_valid;
  assign D        = r_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

`ifdef FPDEC_FASTSHIFT_EN
  logic [11:0] w_shifted;

  assign w_shifted = {8'b0, F} << E;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_d <= 12'h000;
    end else if (w_accept) begin
      r_d <= S ? (12'd0 - w_shifted) : w_shifted;
    end
  end
`else
  logic        r_sign;
  logic [2:0]  r_cnt;
  logic [11:0] r_mag;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid)      w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (r_cnt == 3'd0) w_state_nxt = ST_DONE;
      ST_DONE:  if (out_ready)     w_state_nxt = ST_IDLE;
      default:                     w_state_nxt = ST_IDLE;
    endcase
  end

  // One bit of shift per cycle; D is only written on the final SHIFT cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sign <= 1'b0;
      r_cnt  <= 3'd0;
      r_mag  <= 12'h000;
      r_d    <= 12'h000;
    end else if (w_accept) begin
      r_sign <= S;
      r_cnt  <= E;
      r_mag  <= {8'b0, F};
    end else if (r_state == ST_SHIFT) begin
      if (r_cnt != 3'd0) begin
        r_mag <= r_mag << 1;
        r_cnt <= r_cnt - 3'd1;
      end else begin
        r_d <= r_sign ? (12'd0 - r_mag) : r_mag;
      end
    end
  end
`endif

  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_DONE);
  end

endmodule
